// File: rtl/lsu_pkg.sv
// Load/store control shared types and constants.
// States, funct3 codes, port modes and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  function automatic logic f3_illegal(
    input logic       is_store,
    input logic [2:0] f3
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      is_store: bad = (f3 > F3_W);
      default:  bad = (f3 == 3'b011) ||
                      (f3[2:1] == 2'b11);
    endcase
    return bad;
  endfunction

  // Unsigned variants share the low two bits with
  // their signed twins, so size is funct3[1:0].
  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] o
  );
    logic [3:0] m;
    m = 4'b1111;
    unique case (1'b1)
      (f3[1:0] == SZ_B): m = 4'b0001 << o;
      (f3[1:0] == SZ_H): m = 4'b0011 << o;
      default:           m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: shifts the read word to the
// addressed lane and sign/zero extends it.
import lsu_pkg::*;

module lsu_load_align #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mem_read_data,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] sh;

  always_comb begin
    sh     = mem_read_data >> {offset, 3'b000};
    result = sh;
    unique case (1'b1)
      (funct3 == F3_B):
        result = {{(XLEN-8){sh[7]}}, sh[7:0]};
      (funct3 == F3_BU):
        result = {{(XLEN-8){1'b0}}, sh[7:0]};
      (funct3 == F3_H):
        result = {{(XLEN-16){sh[15]}}, sh[15:0]};
      (funct3 == F3_HU):
        result = {{(XLEN-16){1'b0}}, sh[15:0]};
      default:
        result = sh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage feeding the shared
// instruction/data memory arbiter.
import lsu_pkg::*;

module lsu_ctrl #(
  parameter int XLEN        = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ls_valid,
  output logic            ls_ready,
  input  logic            ls_is_store,
  input  logic [2:0]      ls_funct3,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_store_data,
  input  logic [4:0]      ls_rd,
  output logic            stall_pc,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rw_mode,
  output logic [XLEN-1:0] mem_write_data,
  output logic [3:0]      mem_byte_en,
  output logic            ignore_curr_inst,
  input  logic [XLEN-1:0] mem_read_data,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            st_done,
  output logic            ls_err
);

  lsu_state_e state_q, state_d;

  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_data;
  logic [2:0]      req_f3;
  logic            req_store;
  logic [4:0]      req_rd;

  logic            accept;
  logic            misalign;
  logic            err_in;
  logic [XLEN-1:0] addr_fix;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] ld_result;

  assign accept = ls_valid && ls_ready;

  // Drop the low address bits the access width
  // cannot use; only reaches memory when CHECK_ALIGN=0.
  always_comb begin
    addr_fix = ls_addr;
    misalign = 1'b0;
    unique case (1'b1)
      (ls_funct3[1:0] == SZ_W): begin
        addr_fix[1:0] = 2'b00;
        misalign      = |ls_addr[1:0];
      end
      (ls_funct3[1:0] == SZ_H): begin
        addr_fix[0] = 1'b0;
        misalign    = ls_addr[0];
      end
      default: ;
    endcase
    err_in = f3_illegal(ls_is_store, ls_funct3) ||
             (CHECK_ALIGN && misalign);
  end

  always_comb begin
    lane_wdata = req_data;
    unique case (1'b1)
      (req_f3[1:0] == SZ_B):
        lane_wdata = {4{req_data[7:0]}};
      (req_f3[1:0] == SZ_H):
        lane_wdata = {2{req_data[15:0]}};
      default:
        lane_wdata = req_data;
    endcase
  end

  lsu_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .mem_read_data (mem_read_data),
    .offset        (req_addr[1:0]),
    .funct3        (req_f3),
    .result        (ld_result)
  );

  always_comb begin
    state_d          = state_q;
    ls_ready         = 1'b0;
    stall_pc         = 1'b0;
    mem_addr         = '0;
    mem_rw_mode      = MEM_READ;
    mem_write_data   = '0;
    mem_byte_en      = 4'b0000;
    ignore_curr_inst = 1'b0;
    unique case (state_q)
      IDLE: begin
        ls_ready = 1'b1;
        if (ls_valid && !err_in) state_d = ACCESS;
      end
      ACCESS: begin
        stall_pc    = 1'b1;
        mem_addr    = {req_addr[XLEN-1:2], 2'b00};
        mem_byte_en = lane_mask(req_f3, req_addr[1:0]);
        if (req_store) begin
          mem_rw_mode    = MEM_WRITE;
          mem_write_data = lane_wdata;
          state_d        = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        ignore_curr_inst = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_addr  <= '0;
      req_data  <= '0;
      req_f3    <= 3'b000;
      req_store <= 1'b0;
      req_rd    <= 5'd0;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= '0;
      st_done   <= 1'b0;
      ls_err    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;
      st_done  <= 1'b0;
      ls_err   <= 1'b0;
      if (accept) begin
        req_addr  <= addr_fix;
        req_data  <= ls_store_data;
        req_f3    <= ls_funct3;
        req_store <= ls_is_store;
        req_rd    <= ls_rd;
        ls_err    <= err_in;
      end
      if (state_q == ACCESS && req_store)
        st_done <= 1'b1;
      if (state_q == CAPTURE) begin
        wb_valid <= 1'b1;
        wb_rd    <= req_rd;
        wb_data  <= ld_result;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a synchronous
// memory model standing in for the arbiter.
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        ls_valid;
  logic        ls_ready;
  logic        ls_is_store;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_store_data;
  logic [4:0]  ls_rd;
  logic        stall_pc;
  logic [31:0] mem_addr;
  logic        mem_rw_mode;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic        ignore_curr_inst;
  logic [31:0] mem_read_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        ls_err;

  int n_total;
  int n_pass;

  lsu_ctrl #(
    .XLEN        (32),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ls_valid         (ls_valid),
    .ls_ready         (ls_ready),
    .ls_is_store      (ls_is_store),
    .ls_funct3        (ls_funct3),
    .ls_addr          (ls_addr),
    .ls_store_data    (ls_store_data),
    .ls_rd            (ls_rd),
    .stall_pc         (stall_pc),
    .mem_addr         (mem_addr),
    .mem_rw_mode      (mem_rw_mode),
    .mem_write_data   (mem_write_data),
    .mem_byte_en      (mem_byte_en),
    .ignore_curr_inst (ignore_curr_inst),
    .mem_read_data    (mem_read_data),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .st_done          (st_done),
    .ls_err           (ls_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_word;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_word;
    end else if (stall_pc) begin
      if (mem_rw_mode) begin
        mem_read_data <= mem[mem_addr[11:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_byte_en[b])
            mem[mem_addr[11:2]][8*b +: 8] <=
              mem_write_data[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h",
                  name, act, exp);
  endtask

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] w);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = a[11:2];
    pre_word = w;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  task automatic issue(input logic st,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [4:0] rd);
    @(negedge clk);
    for (int k = 0; k < 20 && !ls_ready; k++)
      @(negedge clk);
    if (!ls_ready) chk("ready_timeout", 32'd0, 32'd1);
    ls_valid      = 1'b1;
    ls_is_store   = st;
    ls_funct3     = f3;
    ls_addr       = a;
    ls_store_data = d;
    ls_rd         = rd;
    @(posedge clk);
    #1;
    ls_valid = 1'b0;
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  rd;
    logic [31:0] pre;
    logic        err;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [31:0] res;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // res: memory word after a store, wb_data for a load
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0,
                 32'h0, 1'b0, 4'b1111, 32'h100,
                 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd0,
                 32'h11223344, 1'b0, 4'b1000, 32'h200,
                 32'hA5A5A5A5, 32'hA5223344};
    vecs[2]  = '{1'b1, 3'b001, 32'h302, 32'h1234CAFE, 5'd0,
                 32'h11223344, 1'b0, 4'b1100, 32'h300,
                 32'hCAFECAFE, 32'hCAFE3344};
    vecs[3]  = '{1'b0, 3'b000, 32'h301, 32'h0, 5'd5,
                 32'h123480FF, 1'b0, 4'b0010, 32'h300,
                 32'h0, 32'hFFFFFF80};
    vecs[4]  = '{1'b0, 3'b100, 32'h301, 32'h0, 5'd6,
                 32'h123480FF, 1'b0, 4'b0010, 32'h300,
                 32'h0, 32'h00000080};
    vecs[5]  = '{1'b0, 3'b001, 32'h402, 32'h0, 5'd7,
                 32'h80010000, 1'b0, 4'b1100, 32'h400,
                 32'h0, 32'hFFFF8001};
    vecs[6]  = '{1'b0, 3'b101, 32'h402, 32'h0, 5'd8,
                 32'h80010000, 1'b0, 4'b1100, 32'h400,
                 32'h0, 32'h00008001};
    vecs[7]  = '{1'b0, 3'b010, 32'h500, 32'h0, 5'd31,
                 32'h13579BDF, 1'b0, 4'b1111, 32'h500,
                 32'h0, 32'h13579BDF};
    vecs[8]  = '{1'b0, 3'b010, 32'h102, 32'h0, 5'd1,
                 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 3'b011, 32'h100, 32'h0, 5'd2,
                 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 3'b100, 32'h100, 32'h5, 5'd0,
                 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b001, 32'h401, 32'h0, 5'd3,
                 32'h0, 1'b1, 4'b0, 32'h0, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h603, 32'h0, 5'd4,
                 32'h7F000000, 1'b0, 4'b1000, 32'h600,
                 32'h0, 32'h0000007F};

    n_total       = 0;
    n_pass        = 0;
    pre_we        = 1'b0;
    pre_idx       = '0;
    pre_word      = '0;
    mem_read_data = '0;
    ls_valid      = 1'b0;
    ls_is_store   = 1'b0;
    ls_funct3     = 3'b000;
    ls_addr       = '0;
    ls_store_data = '0;
    ls_rd         = '0;
    rst           = 1'b1;
    #1;
    chk("rst_stall", {31'd0, stall_pc}, 32'd0);
    chk("rst_rw", {31'd0, mem_rw_mode}, 32'd1);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_be", {28'd0, mem_byte_en}, 32'd0);
    chk("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
    chk("rst_pulses", {30'd0, st_done, ls_err}, 32'd0);
    chk("rst_ready", {31'd0, ls_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      preload(v.maddr, v.pre);
      issue(v.st, v.f3, v.addr, v.sdata, v.rd);
      if (v.err) begin
        chk($sformatf("v%0d_err", i), {31'd0, ls_err}, 32'd1);
        chk($sformatf("v%0d_nostall", i),
            {31'd0, stall_pc}, 32'd0);
        chk($sformatf("v%0d_ready", i),
            {31'd0, ls_ready}, 32'd1);
      end else begin
        chk($sformatf("v%0d_stall", i),
            {31'd0, stall_pc}, 32'd1);
        chk($sformatf("v%0d_maddr", i), mem_addr, v.maddr);
        chk($sformatf("v%0d_rw", i),
            {31'd0, mem_rw_mode}, {31'd0, !v.st});
        chk($sformatf("v%0d_be", i),
            {28'd0, mem_byte_en}, {28'd0, v.be});
        if (v.st)
          chk($sformatf("v%0d_wdata", i),
              mem_write_data, v.wdata);
        @(posedge clk);
        #1;
        if (v.st) begin
          chk($sformatf("v%0d_st_done", i),
              {31'd0, st_done}, 32'd1);
          chk($sformatf("v%0d_memword", i),
              mem[v.maddr[11:2]], v.res);
        end else begin
          chk($sformatf("v%0d_ignore", i),
              {31'd0, ignore_curr_inst}, 32'd1);
          chk($sformatf("v%0d_cap_stall", i),
              {31'd0, stall_pc}, 32'd0);
          @(posedge clk);
          #1;
          chk($sformatf("v%0d_wb_valid", i),
              {31'd0, wb_valid}, 32'd1);
          chk($sformatf("v%0d_wb_data", i), wb_data, v.res);
          chk($sformatf("v%0d_wb_rd", i),
              {27'd0, wb_rd}, {27'd0, v.rd});
        end
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse_end", i),
          {29'd0, st_done, wb_valid, ls_err}, 32'd0);
    end

    // Reset while the store is on the port
    preload(32'h100, 32'h55555555);
    issue(1'b1, 3'b010, 32'h100, 32'hAAAAAAAA, 5'd0);
    chk("rsta_stall_pre", {31'd0, stall_pc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rsta_stall_drop", {31'd0, stall_pc}, 32'd0);
    @(posedge clk);
    #1;
    chk("rsta_no_done", {31'd0, st_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rsta_no_done2", {31'd0, st_done}, 32'd0);
    chk("rsta_memword", mem[10'h040], 32'h55555555);
    chk("rsta_ready", {31'd0, ls_ready}, 32'd1);

    // Reset while the load result is being captured
    preload(32'h800, 32'h12345678);
    issue(1'b0, 3'b010, 32'h800, 32'h0, 5'd3);
    @(posedge clk);
    #1;
    chk("rstc_ignore", {31'd0, ignore_curr_inst}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstc_ignore_drop",
        {31'd0, ignore_curr_inst}, 32'd0);
    @(posedge clk);
    #1;
    chk("rstc_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("rstc_wb_data", wb_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back store then load, request held high
    preload(32'h704, 32'h600DCAFE);
    issue(1'b1, 3'b010, 32'h700, 32'h0BADF00D, 5'd0);
    ls_valid      = 1'b1;
    ls_is_store   = 1'b0;
    ls_funct3     = 3'b010;
    ls_addr       = 32'h704;
    ls_store_data = 32'h0;
    ls_rd         = 5'd9;
    chk("b2b_busy", {31'd0, ls_ready}, 32'd0);
    chk("b2b_st_addr", mem_addr, 32'h700);
    @(posedge clk);
    #1;
    chk("b2b_st_done", {31'd0, st_done}, 32'd1);
    chk("b2b_ready", {31'd0, ls_ready}, 32'd1);
    @(posedge clk);
    #1;
    ls_valid = 1'b0;
    chk("b2b_ld_stall", {31'd0, stall_pc}, 32'd1);
    chk("b2b_ld_addr", mem_addr, 32'h704);
    chk("b2b_ld_rw", {31'd0, mem_rw_mode}, 32'd1);
    chk("b2b_memword", mem[10'h1C0], 32'h0BADF00D);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("b2b_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("b2b_wb_data", wb_data, 32'h600DCAFE);
    chk("b2b_wb_rd", {27'd0, wb_rd}, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
